if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Pipeline register between instruction fetch and decode.
- Captures the fetched instruction and PC+4 each cycle.
- Detects load-use hazards against the instruction in ID/EX. On a hazard it freezes the PC and the IF/ID register and injects a bubble downstream.
- Kills the held instruction when a taken branch flushes the pipeline.

Parameters:
- PC_W, 32, width of the PC+4 value carried to decode.
- INST_W, 32, instruction width; fixed at 32 for this ISA.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_inst  in  32  instruction word from the fetch stage.
- if_pc_plus4  in  PC_W  PC+4 from the fetch stage.
- flush  in  1  taken branch/jump resolved downstream; kill the IF/ID contents.
- ex_mem_read  in  1  the instruction currently in ID/EX is a load (lw).
- ex_rt  in  5  destination register (rt) of the ID/EX instruction.
- id_inst  out  32  registered instruction presented to decode.
- id_pc_plus4  out  PC_W  registered PC+4 presented to decode.
- id_valid  out  1  id_inst is a live instruction, not a bubble.
- pc_write_en  out  1  0 freezes the PC in the fetch stage.
- bubble  out  1  1 forces the ID/EX control signals to zero this cycle.

Behaviour:
- Reset (async, rst_n=0):
  - id_inst=32'h0000_0000 (sll $0 NOP), id_pc_plus4=0, id_valid=0, state=RUN.
  - Outputs during reset: pc_write_en=1, bubble=0.
- Field decode of id_inst: rs=[25:21], rt=[20:16], op=[31:26].
- uses_rt is 1 when op is R-type (0x00), beq (0x04), bne (0x05) or sw (0x2B); otherwise 0.
- load_use (combinational) = id_valid & ex_mem_read & (ex_rt!=0) & ((ex_rt==rs) | (uses_rt & ex_rt==rt)).
- State machine states: RUN, STALL.
  - RUN: hazard = load_use. If hazard and not flush, go to STALL.
  - STALL: hazard is forced to 0. Always return to RUN after exactly one cycle. At most one stall cycle per load, which guarantees forward progress.
- Outputs (combinational):
  - pc_write_en = ~(hazard & ~flush).
  - bubble = hazard | flush.
- Register update priority: flush > hazard > load.
  - flush: id_inst<=0, id_valid<=0, id_pc_plus4<=0, state<=RUN. This holds even during STALL or with a simultaneous hazard.
  - hazard: hold id_inst, id_pc_plus4 and id_valid unchanged.
  - otherwise: id_inst<=if_inst, id_pc_plus4<=if_pc_plus4, id_valid<=1.
- Latency: one cycle from fetch outputs to decode outputs.
- Reset mid-stall: state returns to RUN immediately and the held instruction is discarded.
- No combinational path from if_inst to any output.

Optional Feature:
- Macro: IF_ID_PERF_EN.
- With the macro defined:
  - Adds output ports stall_count[31:0] and flush_count[31:0].
  - stall_count increments on every cycle where hazard & ~flush.
  - flush_count increments on every cycle where flush=1.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0 on rst_n.
- Without the macro: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - Opcode constants OP_RTYPE=6'h00, OP_BEQ=6'h04, OP_BNE=6'h05, OP_LW=6'h23, OP_SW=6'h2B.
  - NOP_INST=32'h0.
  - The state encoding ST_RUN=1'b0, ST_STALL=1'b1.
- One sub-module: hazard_detect, which is purely combinational. Inputs: id_inst, id_valid, ex_mem_read, ex_rt. Output: load_use.

Test Plan:
1. Reset then normal flow: rst_n low 2 cycles, id_valid=0 and id_inst=0. Release rst_n and feed if_inst=0x2109_0004 with pc_plus4=0x4. Next edge id_inst=0x2109_0004, id_valid=1, pc_write_en=1.
2. Load-use stall:
   - Setup: id_inst=add $3,$2,$1 (0x0041_1820), ex_mem_read=1, ex_rt=2.
   - Required: pc_write_en=0, bubble=1, id_inst held for one cycle.
   - Next cycle: with ex_mem_read forced low, pc_write_en=1.
3. rt-zero and non-rt users:
   - ex_rt=0 matching a field → no stall.
   - Instruction is lw (0x23), ex_rt equals its rt field and does not equal rs → no stall.
4. Flush during hazard: set load_use conditions and flush=1 in the same cycle. Required: pc_write_en=1, bubble=1; next edge id_valid=0, id_inst=0, state=RUN.
5. Stall cap: hold ex_mem_read=1 and ex_rt=rs for 3 cycles. Required: exactly one stall cycle, then capture resumes and pc_write_en=1.
6. Async reset mid-stall: drop rst_n while in STALL, between clock edges. Required: outputs go to reset values immediately, without waiting for a clock edge. With IF_ID_PERF_EN defined, check the counter values before and after.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, NOP encoding and IF/ID stall-FSM state encoding.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    // Opcodes that read rt as a source operand (lw only writes it).
    function automatic logic uses_rt(input logic [5:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: r = 1'b1;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// Combinational load-use detector comparing the decode-stage sources against
// the destination of a load sitting in ID/EX.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic [31:0] id_inst,
    input  logic        id_valid,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    output logic        load_use
);

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       unused_imm;

    assign op         = id_inst[31:26];
    assign rs         = id_inst[25:21];
    assign rt         = id_inst[20:16];
    assign unused_imm = ^id_inst[15:0];

    // $0 is hardwired, so a load into it can never create a dependency.
    assign load_use = id_valid & ex_mem_read & (ex_rt != 5'd0)
                    & ((ex_rt == rs) | (uses_rt(op) & (ex_rt == rt)));

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with one-cycle load-use stall and flush kill.
// Optional build macro IF_ID_PERF_EN adds saturating stall/flush counters.
module if_id_stage
    import cpu_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INST_W-1:0] if_inst,
    input  logic [PC_W-1:0]   if_pc_plus4,
    input  logic              flush,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt,
    output logic [INST_W-1:0] id_inst,
    output logic [PC_W-1:0]   id_pc_plus4,
    output logic              id_valid,
    output logic              pc_write_en,
    output logic              bubble
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]       stall_count,
    output logic [31:0]       flush_count
`endif
);

    logic [INST_W-1:0] inst_q, inst_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [0:0]        state_q, state_d;
    logic              load_use;
    logic              hazard;

    hazard_detect u_hazard_detect (
        .id_inst     (inst_q),
        .id_valid    (valid_q),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .load_use    (load_use)
    );

    // A single stall per load is enough: by then the load has reached MEM.
    assign hazard      = (state_q == ST_RUN) & load_use;
    assign pc_write_en = ~(hazard & ~flush);
    assign bubble      = hazard | flush;

    always_comb begin
        inst_d  = if_inst;
        pc_d    = if_pc_plus4;
        valid_d = 1'b1;
        state_d = ST_RUN;
        if (flush) begin
            inst_d  = NOP_INST;
            pc_d    = '0;
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else if (hazard) begin
            inst_d  = inst_q;
            pc_d    = pc_q;
            valid_d = valid_q;
            state_d = ST_STALL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q  <= NOP_INST;
            pc_q    <= '0;
            valid_q <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end

    assign id_inst     = inst_q;
    assign id_pc_plus4 = pc_q;
    assign id_valid    = valid_q;

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hazard && !flush && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush && (flush_cnt_q != 32'hFFFF_FFFF))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_if_id_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_inst;
    logic [31:0] if_pc_plus4;
    logic        flush;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic [31:0] id_inst;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic        pc_write_en;
    logic        bubble;
`ifdef IF_ID_PERF_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;
`endif

    if_id_stage #(.PC_W(32), .INST_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_inst     (if_inst),
        .if_pc_plus4 (if_pc_plus4),
        .flush       (flush),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_inst     (id_inst),
        .id_pc_plus4 (id_pc_plus4),
        .id_valid    (id_valid),
        .pc_write_en (pc_write_en),
        .bubble      (bubble)
`ifdef IF_ID_PERF_EN
        ,
        .stall_count (stall_count),
        .flush_count (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural model: what decode holds, and whether the last cycle already stalled.
    logic [31:0] m_inst, m_pc;
    logic        m_valid, m_stalled;
    longint      m_stalls, m_flushes;
    logic        last_pwe, last_bub;

    function automatic logic reads_rt(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    endfunction

    function automatic logic model_hazard(input logic mr, input logic [4:0] ert);
        logic [4:0] rs, rt;
        rs = m_inst[25:21];
        rt = m_inst[20:16];
        if (m_stalled || !m_valid || !mr || ert == 5'd0) return 1'b0;
        return (ert == rs) || (reads_rt(m_inst[31:26]) && ert == rt);
    endfunction

    task automatic model_reset();
        m_inst = 32'h0; m_pc = 32'h0; m_valid = 1'b0; m_stalled = 1'b0;
        m_stalls = 0; m_flushes = 0;
    endtask

    task automatic check_counters();
`ifdef IF_ID_PERF_EN
        chk("stall_count", stall_count, m_stalls[31:0]);
        chk("flush_count", flush_count, m_flushes[31:0]);
`endif
    endtask

    task automatic step(input logic [31:0] inst, input logic [31:0] pc,
                        input logic fl, input logic mr, input logic [4:0] ert);
        logic hz;
        @(negedge clk);
        if_inst = inst; if_pc_plus4 = pc; flush = fl; ex_mem_read = mr; ex_rt = ert;
        #1;
        hz = model_hazard(mr, ert);
        last_pwe = pc_write_en;
        last_bub = bubble;
        chk("pc_write_en", {31'b0, pc_write_en}, {31'b0, !(hz && !fl)});
        chk("bubble", {31'b0, bubble}, {31'b0, hz || fl});
        @(posedge clk);
        if (fl) begin
            m_inst = 32'h0; m_pc = 32'h0; m_valid = 1'b0; m_stalled = 1'b0;
            m_flushes++;
        end else if (hz) begin
            m_stalled = 1'b1;
            m_stalls++;
        end else begin
            m_inst = inst; m_pc = pc; m_valid = 1'b1; m_stalled = 1'b0;
        end
        #1;
        chk("id_inst", id_inst, m_inst);
        chk("id_pc_plus4", id_pc_plus4, m_pc);
        chk("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
        check_counters();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0] ops [6];
        ops[0] = 6'h00; ops[1] = 6'h04; ops[2] = 6'h05;
        ops[3] = 6'h23; ops[4] = 6'h2B; ops[5] = 6'h08;
        return {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 16'($urandom)};
    endfunction

    initial begin
        rst_n = 1'b0; if_inst = 32'h0; if_pc_plus4 = 32'h0;
        flush = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
        model_reset();
        last_pwe = 1'b0; last_bub = 1'b0;

        // 1: reset values, then first capture
        repeat (2) @(posedge clk);
        #1;
        chk("rst_id_inst", id_inst, 32'h0);
        chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_pc_write_en", {31'b0, pc_write_en}, 32'h1);
        chk("rst_bubble", {31'b0, bubble}, 32'h0);
        check_counters();
        @(negedge clk); rst_n = 1'b1;
        step(32'h2109_0004, 32'h4, 0, 0, 5'd0);
        chk("t1_inst", id_inst, 32'h2109_0004);
        chk("t1_valid", {31'b0, id_valid}, 32'h1);

        // 2: load-use stall on rs
        step(32'h0041_1820, 32'h8, 0, 0, 5'd0);
        step(32'h2109_0004, 32'hC, 0, 1, 5'd2);
        chk("t2_pwe_stall", {31'b0, last_pwe}, 32'h0);
        chk("t2_bubble", {31'b0, last_bub}, 32'h1);
        chk("t2_held", id_inst, 32'h0041_1820);
        step(32'h2109_0004, 32'hC, 0, 0, 5'd2);
        chk("t2_pwe_resume", {31'b0, last_pwe}, 32'h1);

        // 3: ex_rt=0 and lw rt (not a source) never stall
        step(32'h0000_1020, 32'h10, 0, 0, 5'd0);
        step(32'h8C43_0000, 32'h14, 0, 1, 5'd0);
        chk("t3_rt0_pwe", {31'b0, last_pwe}, 32'h1);
        step(32'h2109_0004, 32'h18, 0, 1, 5'd3);
        chk("t3_lw_rt_pwe", {31'b0, last_pwe}, 32'h1);

        // 4: flush wins over a simultaneous hazard
        step(32'h0041_1820, 32'h1C, 0, 0, 5'd0);
        step(32'h2109_0004, 32'h20, 1, 1, 5'd1);
        chk("t4_pwe", {31'b0, last_pwe}, 32'h1);
        chk("t4_bubble", {31'b0, last_bub}, 32'h1);
        chk("t4_valid", {31'b0, id_valid}, 32'h0);
        chk("t4_inst", id_inst, 32'h0);

        // 5: stall capped at one cycle with the load still in ID/EX
        step(32'h00A6_3820, 32'h24, 0, 0, 5'd0);
        step(32'h2109_0004, 32'h28, 0, 1, 5'd5);
        chk("t5_pwe_c1", {31'b0, last_pwe}, 32'h0);
        step(32'h2109_0004, 32'h28, 0, 1, 5'd5);
        chk("t5_pwe_c2", {31'b0, last_pwe}, 32'h1);
        step(32'h2109_0004, 32'h2C, 0, 1, 5'd5);
        chk("t5_pwe_c3", {31'b0, last_pwe}, 32'h1);

        // 6: async reset while in STALL
        step(32'h00A6_3820, 32'h30, 0, 0, 5'd0);
        step(32'h2109_0004, 32'h34, 0, 1, 5'd5);
        #2;
        ex_mem_read = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_inst", id_inst, 32'h0);
        chk("t6_pc", id_pc_plus4, 32'h0);
        chk("t6_valid", {31'b0, id_valid}, 32'h0);
        chk("t6_pwe", {31'b0, pc_write_en}, 32'h1);
        chk("t6_bubble", {31'b0, bubble}, 32'h0);
        check_counters();
        @(negedge clk); rst_n = 1'b1;
        step(32'h00A6_3820, 32'h4, 0, 0, 5'd0);
        step(32'h2109_0004, 32'h8, 0, 1, 5'd5);
        chk("t6_run_after_rst", {31'b0, last_pwe}, 32'h0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(rand_inst(), $urandom, ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
